regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the multicycle/pipelined ARM cores.
//  Provides NUM_RD combinational read ports and NUM_WR prioritised write ports, with optional write-to-read bypass.
//  The PC register is read from an external input, and a per-register busy scoreboard covers outstanding multicycle loads.
//  Sits between decode (reads) and writeback/load-return paths (writes).
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   4   register address width; depth = 2**ADDR_W entries
//  NUM_RD   3   number of read ports
//  NUM_WR   2   number of write ports; higher index = higher priority
//  PC_REG   15  address served by pc_in; never stored or reserved
//  BYPASS   1   1: a read of an address written this cycle returns the winning write data
// PORTS
//  clk       in   1               rising-edge clock
//  reset_n   in   1               async active-low reset
//  rd_addr   in   NUM_RD*ADDR_W   packed read addresses; port i = [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   packed read data
//  rd_busy   out  NUM_RD          busy bit of each read address (0 for PC_REG)
//  we        in   NUM_WR          write enables
//  wa        in   NUM_WR*ADDR_W   packed write addresses
//  wd        in   NUM_WR*DATA_W   packed write data
//  pc_in     in   DATA_W          value returned for reads of PC_REG (PC+8 supplied by datapath)
//  rsv_en    in   1               reserve rsv_addr (load issued)
//  rsv_addr  in   ADDR_W          register to mark busy
//  busy_vec  out  2**ADDR_W       registered scoreboard
//  busy_cnt  out  ADDR_W+1        registered popcount of busy_vec
//  rsv_err   out  1               registered 1-cycle pulse: reserve hit an already-busy reg
// BEHAVIOUR
//  - Reset (reset_n=0, async): all entries 0, busy_vec 0, busy_cnt 0, rsv_err 0. Reset mid-operation discards pending writes/reserves.
//  - Write: at posedge, for each entry, the highest-index port with we[k]=1 and wa[k]=entry wins; lower ports are dropped.
//  - Writes and reserves addressed to PC_REG are ignored (no storage, no busy change, no rsv_err).
//  - Read: combinational, 0-cycle latency. PC_REG -> pc_in. Otherwise BYPASS=1 with a matching write this cycle -> winning wd;
//    otherwise the stored value. BYPASS=0 -> stored value (new data visible the cycle after the edge).
//  - Scoreboard per entry at posedge: rsv_en & rsv_addr==e -> busy=1; else any write to e -> busy=0; else hold.
//    A reserve and a write to the same entry in one cycle: reserve wins (new load supersedes); the write data is still stored.
//  - rsv_err <= rsv_en & busy_vec[rsv_addr] & (rsv_addr!=PC_REG); cleared the next cycle unless re-asserted.
//  - busy_cnt = popcount of the next busy_vec, registered together with it (always consistent with busy_vec).
//  - rd_busy[i] = busy_vec[rd_addr[i]] (registered state, no bypass of same-cycle clears).
//  - Unused entries when 2**ADDR_W > PC_REG+1 behave as normal registers.
// STRUCTURE
//  - regfile_pkg: PC_REG default, popcount function, default widths.
//  - Sub-module regfile_wr_arb: per-entry priority select (NUM_WR enables/addrs -> hit, data); instantiated 2**ADDR_W times
//    and reused by the bypass path.
//  - Storage, scoreboard and counters live in regfile_mp; no other hierarchy.
// TESTING
//  1 Reset: write r3=0xDEAD, then assert reset_n=0 between edges -> rd r3=0, busy_vec=0, busy_cnt=0 immediately.
//  2 Priority: we=2'b11, wa0=wa1=5, wd0=0x11, wd1=0x22 -> after edge r5=0x22; BYPASS=1 same-cycle read r5=0x22.
//  3 PC: pc_in=0x108, read r15 -> 0x108; write r15=0x55, rsv r15 -> r15 still pc_in, busy_vec[15]=0, rsv_err=0.
//  4 Scoreboard: rsv r2 -> busy_cnt=1, rd_busy=1 on r2; rsv r2 again -> rsv_err=1 for one cycle; write r2 -> busy clear, cnt=0.
//  5 Collision: rsv r7 and write r7=0x77 same cycle -> r7=0x77 and busy_vec[7]=1.
//  6 BYPASS=0: write r4=0x9 -> same-cycle read returns old value, next cycle returns 0x9.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_PC_REG = 15;
   localparam int POP_MAX_W  = 256;

   // Callers zero-extend their vector to POP_MAX_W bits (depth up to 256 entries).
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < POP_MAX_W; i++)
         cnt = cnt + 32'(v[i]);
      return cnt;
   endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-entry write priority select: the highest-index enabled port aimed at addr wins.
module regfile_wr_arb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int NUM_WR = 2
) (
   input  logic [ADDR_W-1:0]        addr,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] wa,
   input  logic [NUM_WR*DATA_W-1:0] wd,
   output logic                     hit,
   output logic [DATA_W-1:0]        data
);

   always_comb begin
      hit  = 1'b0;
      data = '0;
      // Ascending scan so a later (higher-priority) port overrides earlier matches.
      for (int k = 0; k < NUM_WR; k++) begin
         if (we[k] && (wa[k*ADDR_W +: ADDR_W] == addr)) begin
            hit  = 1'b1;
            data = wd[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with prioritised writes, optional write bypass,
// an externally supplied PC register and a busy scoreboard for outstanding loads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 3,
   parameter int NUM_WR = 2,
   parameter int PC_REG = DEF_PC_REG,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] wa,
   input  logic [NUM_WR*DATA_W-1:0] wd,
   input  logic [DATA_W-1:0]        pc_in,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [2**ADDR_W-1:0]     busy_vec,
   output logic [ADDR_W:0]          busy_cnt,
   output logic                     rsv_err
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);

   logic [DATA_W-1:0] mem     [DEPTH];
   logic [DATA_W-1:0] wr_data [DEPTH];
   logic [DEPTH-1:0]  wr_hit;
   logic [DEPTH-1:0]  busy_nxt;
   logic              rsv_ok;

   for (genvar e = 0; e < DEPTH; e++) begin : gen_arb
      regfile_wr_arb #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_arb (
         .addr (ADDR_W'(e)),
         .we   (we),
         .wa   (wa),
         .wd   (wd),
         .hit  (wr_hit[e]),
         .data (wr_data[e])
      );
   end

   assign rsv_ok = rsv_en && (rsv_addr != PC_A);

   // A reserve outranks a same-cycle write: the new load supersedes the older result.
   always_comb begin
      busy_nxt = busy_vec;
      for (int e = 0; e < DEPTH; e++) begin
         if (e == PC_REG)
            busy_nxt[e] = 1'b0;
         else if (rsv_ok && (rsv_addr == ADDR_W'(e)))
            busy_nxt[e] = 1'b1;
         else if (wr_hit[e])
            busy_nxt[e] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < DEPTH; e++)
            mem[e] <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++)
            if (wr_hit[e] && (e != PC_REG))
               mem[e] <= wr_data[e];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_vec <= '0;
         busy_cnt <= '0;
         rsv_err  <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;
         busy_cnt <= CNT_W'(popcount(POP_MAX_W'(busy_nxt)));
         rsv_err  <= rsv_ok && busy_vec[rsv_addr];
      end
   end

   // Read ports reuse the per-entry arbiter results for the bypass path.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_busy[i] = (rd_addr[i*ADDR_W +: ADDR_W] != PC_A) && busy_vec[rd_addr[i*ADDR_W +: ADDR_W]];
         if (rd_addr[i*ADDR_W +: ADDR_W] == PC_A)
            rd_data[i*DATA_W +: DATA_W] = pc_in;
         else if ((BYPASS != 0) && wr_hit[rd_addr[i*ADDR_W +: ADDR_W]])
            rd_data[i*DATA_W +: DATA_W] = wr_data[rd_addr[i*ADDR_W +: ADDR_W]];
         else
            rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: BYPASS=1 and BYPASS=0 instances share stimulus and are checked
// every cycle against a behavioural register-file model plus directed literal expectations.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NR = 3;
   localparam int NW = 2;
   localparam int NE = 16;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [NR*AW-1:0] rd_addr;
   logic [NW-1:0]    we;
   logic [NW*AW-1:0] wa;
   logic [NW*DW-1:0] wd;
   logic [DW-1:0]    pc_in;
   logic             rsv_en;
   logic [AW-1:0]    rsv_addr;

   logic [NR*DW-1:0] rd_data_a, rd_data_b;
   logic [NR-1:0]    rd_busy_a, rd_busy_b;
   logic [NE-1:0]    busy_vec_a, busy_vec_b;
   logic [AW:0]      busy_cnt_a, busy_cnt_b;
   logic             rsv_err_a, rsv_err_b;

   int n_total = 0;
   int n_pass  = 0;

   logic [DW-1:0] m_mem [NE];
   logic [NE-1:0] m_busy;
   logic          m_err;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .PC_REG(15), .BYPASS(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .we(we), .wa(wa), .wd(wd), .pc_in(pc_in), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_vec(busy_vec_a), .busy_cnt(busy_cnt_a), .rsv_err(rsv_err_a));

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .PC_REG(15), .BYPASS(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .we(we), .wa(wa), .wd(wd), .pc_in(pc_in), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_vec(busy_vec_b), .busy_cnt(busy_cnt_b), .rsv_err(rsv_err_b));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
   endtask

   // Model: writes land in port order so the last port wins, then a reserve overrides busy.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < NE; e++) m_mem[e] = '0;
         m_busy = '0;
         m_err  = 1'b0;
      end else begin
         m_err = rsv_en && (rsv_addr != 4'd15) && m_busy[rsv_addr];
         for (int k = 0; k < NW; k++) begin
            if (we[k] && (wa[k*AW +: AW] != 4'd15)) begin
               m_mem[wa[k*AW +: AW]]  = wd[k*DW +: DW];
               m_busy[wa[k*AW +: AW]] = 1'b0;
            end
         end
         if (rsv_en && (rsv_addr != 4'd15)) m_busy[rsv_addr] = 1'b1;
      end
   end

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      if (a == 4'd15) return pc_in;
      if (byp)
         for (int k = NW-1; k >= 0; k--)
            if (we[k] && (wa[k*AW +: AW] == a)) return wd[k*DW +: DW];
      return m_mem[a];
   endfunction

   always @(negedge clk) begin
      logic [AW-1:0] a;
      for (int i = 0; i < NR; i++) begin
         a = rd_addr[i*AW +: AW];
         chk($sformatf("mdl_rd%0d_byp", i), 64'(rd_data_a[i*DW +: DW]), 64'(exp_rd(a, 1'b1)));
         chk($sformatf("mdl_rd%0d_nobyp", i), 64'(rd_data_b[i*DW +: DW]), 64'(exp_rd(a, 1'b0)));
         chk($sformatf("mdl_rdbusy%0d", i), 64'({rd_busy_a[i], rd_busy_b[i]}),
             64'({2{(a != 4'd15) && m_busy[a]}}));
      end
      chk("mdl_busy_vec", 64'({busy_vec_a, busy_vec_b}), 64'({m_busy, m_busy}));
      chk("mdl_busy_cnt", 64'({busy_cnt_a, busy_cnt_b}), 64'({5'($countones(m_busy)), 5'($countones(m_busy))}));
      chk("mdl_rsv_err", 64'({rsv_err_a, rsv_err_b}), 64'({m_err, m_err}));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = '0; rsv_en = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; rd_addr = '0; we = '0; wa = '0; wd = '0;
      pc_in = '0; rsv_en = 1'b0; rsv_addr = '0;
      step(); step();
      reset_n = 1'b1;
      #1;
      chk("rst_busy_vec", 64'(busy_vec_a), 64'h0);
      chk("rst_busy_cnt", 64'(busy_cnt_a), 64'h0);
      chk("rst_rsv_err", 64'(rsv_err_a), 64'h0);
      chk("rst_rd0", 64'(rd_data_a[0 +: DW]), 64'h0);

      // Async reset between edges
      we = 2'b01; wa[3:0] = 4'd3; wd[31:0] = 32'hDEAD; rsv_en = 1'b1; rsv_addr = 4'd6;
      step(); idle(); rd_addr[3:0] = 4'd3;
      #1;
      chk("t1_r3_written", 64'(rd_data_a[0 +: DW]), 64'hDEAD);
      chk("t1_cnt_before", 64'(busy_cnt_a), 64'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_r3_after_rst", 64'(rd_data_a[0 +: DW]), 64'h0);
      chk("t1_busy_after_rst", 64'(busy_vec_a), 64'h0);
      chk("t1_cnt_after_rst", 64'(busy_cnt_a), 64'h0);
      step(); reset_n = 1'b1;

      // Same-address priority
      we = 2'b11; wa = {4'd5, 4'd5}; wd = {32'h22, 32'h11}; rd_addr[3:0] = 4'd5;
      #1;
      chk("t2_bypass_r5", 64'(rd_data_a[0 +: DW]), 64'h22);
      chk("t2_nobypass_r5", 64'(rd_data_b[0 +: DW]), 64'h0);
      step(); idle();
      #1;
      chk("t2_r5_stored", 64'(rd_data_b[0 +: DW]), 64'h22);

      // PC register
      pc_in = 32'h108; rd_addr[7:4] = 4'd15;
      #1;
      chk("t3_pc_read", 64'(rd_data_a[DW +: DW]), 64'h108);
      we = 2'b01; wa[3:0] = 4'd15; wd[31:0] = 32'h55; rsv_en = 1'b1; rsv_addr = 4'd15;
      step(); idle();
      #1;
      chk("t3_pc_after_wr", 64'(rd_data_b[DW +: DW]), 64'h108);
      chk("t3_pc_not_busy", 64'(busy_vec_a[15]), 64'h0);
      chk("t3_pc_no_err", 64'(rsv_err_a), 64'h0);

      // Scoreboard
      rsv_en = 1'b1; rsv_addr = 4'd2; rd_addr[11:8] = 4'd2;
      step(); idle();
      #1;
      chk("t4_cnt1", 64'(busy_cnt_a), 64'h1);
      chk("t4_rd_busy", 64'(rd_busy_a[2]), 64'h1);
      chk("t4_no_err", 64'(rsv_err_a), 64'h0);
      rsv_en = 1'b1; rsv_addr = 4'd2;
      step(); idle();
      #1;
      chk("t4_err_pulse", 64'(rsv_err_a), 64'h1);
      step();
      chk("t4_err_clear", 64'(rsv_err_a), 64'h0);
      we = 2'b01; wa[3:0] = 4'd2; wd[31:0] = 32'h2222;
      step(); idle();
      #1;
      chk("t4_busy_clear", 64'(busy_vec_a[2]), 64'h0);
      chk("t4_cnt0", 64'(busy_cnt_a), 64'h0);
      chk("t4_r2_data", 64'(rd_data_a[2*DW +: DW]), 64'h2222);

      // Reserve and write collide
      we = 2'b10; wa[7:4] = 4'd7; wd[63:32] = 32'h77; rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr[3:0] = 4'd7;
      step(); idle();
      #1;
      chk("t5_r7_data", 64'(rd_data_b[0 +: DW]), 64'h77);
      chk("t5_r7_busy", 64'(busy_vec_a[7]), 64'h1);
      chk("t5_cnt", 64'(busy_cnt_a), 64'h1);

      // No-bypass visibility
      we = 2'b01; wa[3:0] = 4'd4; wd[31:0] = 32'h9; rd_addr[3:0] = 4'd4;
      #1;
      chk("t6_same_cycle_old", 64'(rd_data_b[0 +: DW]), 64'h0);
      chk("t6_same_cycle_byp", 64'(rd_data_a[0 +: DW]), 64'h9);
      step(); idle();
      #1;
      chk("t6_next_cycle", 64'(rd_data_b[0 +: DW]), 64'h9);

      // Two ports to distinct addresses both land
      we = 2'b11; wa = {4'd9, 4'd8}; wd = {32'h99, 32'h88}; rd_addr = {4'd9, 4'd8, 4'd0};
      step(); idle();
      #1;
      chk("t7_r8", 64'(rd_data_b[DW +: DW]), 64'h88);
      chk("t7_r9", 64'(rd_data_b[2*DW +: DW]), 64'h99);

      // Directed sweep exercised by the model comparisons
      for (int i = 0; i < 32; i++) begin
         we       = 2'(i);
         wa       = {4'((i * 3) % 16), 4'(i % 16)};
         wd       = {32'(32'hA000 + i), 32'(32'h1010 * i)};
         rsv_en   = (i % 3) == 0;
         rsv_addr = 4'((i * 5) % 16);
         rd_addr  = {4'((i * 7) % 16), 4'((i + 1) % 16), 4'(i % 16)};
         pc_in    = 32'(32'h200 + 4 * i);
         step();
      end
      idle();
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
